rv_mc_ctrl: RTL and testbench

- Multi-cycle control unit for the multicycle RISC-V RV32I core variant; sits at the driving end of the ALU op/operand interface.
- Sequences fetch/decode/execute/memory/writeback and decodes each instruction into an `op_enum_alu` code plus operand selects.
- Drives the memory request handshake and the register-file, PC and IR write enables.
- Consumes ALU status bits for branch resolution.

---
 rtl/risc_pkg.sv | 72 +++++++
 rtl/rv_alu_op_decode.sv | 50 +++++
 rtl/rv_mc_ctrl.sv | 202 ++++++++++++++++++++
 tb/tb_rv_mc_ctrl.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/risc_pkg.sv
// Shared RV32I definitions: ALU op codes, controller states, opcodes and datapath select encodings.
package risc_pkg;

  typedef enum logic [3:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_SLL,
    ALU_SLT,
    ALU_SLTU,
    ALU_XOR,
    ALU_SRL,
    ALU_SRA,
    ALU_OR,
    ALU_AND
  } op_enum_alu;

  typedef enum logic [3:0] {
    FETCH,
    DECODE,
    EXEC_R,
    EXEC_I,
    MEM_ADDR,
    MEM_RD,
    MEM_WR,
    WB_ALU,
    WB_MEM,
    BRANCH,
    JAL,
    JALR,
    LUI,
    AUIPC,
    TRAP
  } ctrl_state_e;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  typedef enum logic [1:0] {
    SRC_A_RS1    = 2'd0,
    SRC_A_PC     = 2'd1,
    SRC_A_OLD_PC = 2'd2,
    SRC_A_ZERO   = 2'd3
  } src_a_sel_e;

  typedef enum logic [1:0] {
    SRC_B_RS2  = 2'd0,
    SRC_B_IMM  = 2'd1,
    SRC_B_FOUR = 2'd2
  } src_b_sel_e;

  typedef enum logic [2:0] {
    IMM_I = 3'd0,
    IMM_S = 3'd1,
    IMM_B = 3'd2,
    IMM_U = 3'd3,
    IMM_J = 3'd4
  } imm_sel_e;

  typedef enum logic [1:0] {
    WB_SEL_ALU = 2'd0,
    WB_SEL_MEM = 2'd1,
    WB_SEL_PC4 = 2'd2
  } wb_sel_e;

endpackage

// File: rtl/rv_alu_op_decode.sv
// Combinational ALU op decode for register/immediate arithmetic and conditional branches.
module rv_alu_op_decode
  import risc_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  output op_enum_alu alu_op,
  output logic       invalid
);

  always_comb begin
    alu_op  = ALU_ADD;
    invalid = 1'b0;
    case (opcode)
      OPC_OP, OPC_OP_IMM: begin
        case (funct3)
          3'b000: if (opcode == OPC_OP && funct7[5]) alu_op = ALU_SUB;
                  else alu_op = ALU_ADD;
          3'b001: alu_op = ALU_SLL;
          3'b010: alu_op = ALU_SLT;
          3'b011: alu_op = ALU_SLTU;
          3'b100: alu_op = ALU_XOR;
          3'b101: if (funct7[5]) alu_op = ALU_SRA;
                  else alu_op = ALU_SRL;
          3'b110: alu_op = ALU_OR;
          default: alu_op = ALU_AND;
        endcase
        // In I-type only the shift forms carry a funct7; elsewhere those bits are immediate.
        if (opcode == OPC_OP)
          invalid = !((funct7 == 7'b0000000) ||
                      (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101)));
        else if (funct3 == 3'b001)
          invalid = (funct7 != 7'b0000000);
        else if (funct3 == 3'b101)
          invalid = (funct7 != 7'b0000000) && (funct7 != 7'b0100000);
      end
      OPC_BRANCH: begin
        case (funct3[2:1])
          2'b00:   alu_op = ALU_SUB;
          2'b01:   invalid = 1'b1;
          2'b10:   alu_op = ALU_SLT;
          default: alu_op = ALU_SLTU;
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/rv_mc_ctrl.sv
// Multi-cycle RV32I control unit: sequences each instruction and drives ALU, memory and write-enable controls.
module rv_mc_ctrl
  import risc_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter int RESET_PC_SEL = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instr,
  input  logic        mem_ready,
  input  logic        alu_res_zero,
  input  logic        alu_res_lsb,
  output op_enum_alu  alu_op,
  output logic [1:0]  src_a_sel,
  output logic [1:0]  src_b_sel,
  output logic [2:0]  imm_sel,
  output logic        mem_req,
  output logic        mem_we,
  output logic        addr_sel,
  output logic        ir_we,
  output logic        pc_we,
  output logic        rf_we,
  output logic [1:0]  wb_sel,
  output logic        illegal
);

  if (XLEN != 32) begin : g_xlen_check
    $error("rv_mc_ctrl supports XLEN=32 only");
  end

  ctrl_state_e state;
  op_enum_alu  dec_op;
  logic        dec_invalid;
  logic        branch_taken;
  logic        mem_req_c, mem_we_c, ir_we_c, pc_we_c, rf_we_c;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        unused_bits;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  // Register indices are consumed by the datapath; RESET_PC_SEL is a datapath-side reset vector choice.
  assign unused_bits = ^{instr[24:15], instr[11:7], 1'(RESET_PC_SEL)};

  rv_alu_op_decode u_alu_op_decode (
    .opcode  (opcode),
    .funct3  (funct3),
    .funct7  (instr[31:25]),
    .alu_op  (dec_op),
    .invalid (dec_invalid)
  );

  always_comb begin
    case (funct3[2:1])
      2'b00:   branch_taken = alu_res_zero ^ funct3[0];
      2'b01:   branch_taken = 1'b0;
      default: branch_taken = alu_res_lsb ^ funct3[0];
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= FETCH;
      illegal <= 1'b0;
    end else begin
      case (state)
        FETCH:  if (mem_ready) state <= DECODE;
        DECODE: begin
          case (opcode)
            OPC_OP:               state <= EXEC_R;
            OPC_OP_IMM:           state <= EXEC_I;
            OPC_LOAD, OPC_STORE:  state <= MEM_ADDR;
            OPC_BRANCH:           state <= BRANCH;
            OPC_JAL:              state <= JAL;
            OPC_JALR:             state <= JALR;
            OPC_LUI:              state <= LUI;
            OPC_AUIPC:            state <= AUIPC;
            default: begin
              state   <= TRAP;
              illegal <= 1'b1;
            end
          endcase
        end
        EXEC_R, EXEC_I: begin
          if (dec_invalid) begin
            state   <= TRAP;
            illegal <= 1'b1;
          end else begin
            state <= WB_ALU;
          end
        end
        MEM_ADDR: if (opcode == OPC_STORE) state <= MEM_WR;
                  else state <= MEM_RD;
        MEM_RD:   if (mem_ready) state <= WB_MEM;
        MEM_WR:   if (mem_ready) state <= FETCH;
        BRANCH: begin
          if (dec_invalid) begin
            state   <= TRAP;
            illegal <= 1'b1;
          end else begin
            state <= FETCH;
          end
        end
        TRAP:    illegal <= 1'b1;
        default: state <= FETCH;
      endcase
    end
  end

  always_comb begin
    alu_op    = ALU_ADD;
    src_a_sel = SRC_A_RS1;
    src_b_sel = SRC_B_RS2;
    imm_sel   = IMM_I;
    addr_sel  = 1'b0;
    wb_sel    = WB_SEL_ALU;
    mem_req_c = 1'b0;
    mem_we_c  = 1'b0;
    ir_we_c   = 1'b0;
    pc_we_c   = 1'b0;
    rf_we_c   = 1'b0;
    case (state)
      FETCH: begin
        mem_req_c = 1'b1;
        src_a_sel = SRC_A_PC;
        src_b_sel = SRC_B_FOUR;
        ir_we_c   = mem_ready;
        pc_we_c   = mem_ready;
      end
      DECODE: begin
        src_a_sel = SRC_A_OLD_PC;
        src_b_sel = SRC_B_IMM;
        imm_sel   = IMM_B;
      end
      EXEC_R: alu_op = dec_op;
      EXEC_I: begin
        alu_op    = dec_op;
        src_b_sel = SRC_B_IMM;
      end
      MEM_ADDR: begin
        src_b_sel = SRC_B_IMM;
        if (opcode == OPC_STORE) imm_sel = IMM_S;
      end
      MEM_RD: begin
        mem_req_c = 1'b1;
        addr_sel  = 1'b1;
      end
      MEM_WR: begin
        mem_req_c = 1'b1;
        mem_we_c  = 1'b1;
        addr_sel  = 1'b1;
        imm_sel   = IMM_S;
      end
      WB_ALU: rf_we_c = 1'b1;
      WB_MEM: begin
        rf_we_c = 1'b1;
        wb_sel  = WB_SEL_MEM;
      end
      // PC is loaded from the branch target latched during DECODE.
      BRANCH: begin
        alu_op  = dec_op;
        pc_we_c = branch_taken && !dec_invalid;
      end
      JAL: begin
        src_a_sel = SRC_A_OLD_PC;
        src_b_sel = SRC_B_IMM;
        imm_sel   = IMM_J;
        rf_we_c   = 1'b1;
        pc_we_c   = 1'b1;
        wb_sel    = WB_SEL_PC4;
      end
      JALR: begin
        src_b_sel = SRC_B_IMM;
        rf_we_c   = 1'b1;
        pc_we_c   = 1'b1;
        wb_sel    = WB_SEL_PC4;
      end
      LUI: begin
        src_a_sel = SRC_A_ZERO;
        src_b_sel = SRC_B_IMM;
        imm_sel   = IMM_U;
        rf_we_c   = 1'b1;
      end
      AUIPC: begin
        src_a_sel = SRC_A_OLD_PC;
        src_b_sel = SRC_B_IMM;
        imm_sel   = IMM_U;
        rf_we_c   = 1'b1;
      end
      default: ;
    endcase
  end

  // A reset cycle must never let a write or request escape, even mid-instruction.
  assign mem_req = mem_req_c & rst_n;
  assign mem_we  = mem_we_c  & rst_n;
  assign ir_we   = ir_we_c   & rst_n;
  assign pc_we   = pc_we_c   & rst_n;
  assign rf_we   = rf_we_c   & rst_n;

endmodule

// File: tb/tb_rv_mc_ctrl.sv
// Directed bench for rv_mc_ctrl: walks representative instructions through the sequencer cycle by cycle.
module tb_rv_mc_ctrl;
  import risc_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] instr;
  logic        mem_ready;
  logic        alu_res_zero;
  logic        alu_res_lsb;
  op_enum_alu  alu_op;
  logic [1:0]  src_a_sel;
  logic [1:0]  src_b_sel;
  logic [2:0]  imm_sel;
  logic        mem_req;
  logic        mem_we;
  logic        addr_sel;
  logic        ir_we;
  logic        pc_we;
  logic        rf_we;
  logic [1:0]  wb_sel;
  logic        illegal;

  int errors = 0;
  int checks = 0;

  localparam logic [31:0] I_ADD  = 32'h002081B3;
  localparam logic [31:0] I_SUB  = 32'h402081B3;
  localparam logic [31:0] I_SRAI = 32'h40335293;
  localparam logic [31:0] I_BAD  = 32'h02208133;
  localparam logic [31:0] I_LW   = 32'h00412083;
  localparam logic [31:0] I_SW   = 32'h0020A423;
  localparam logic [31:0] I_BEQ  = 32'h00208463;
  localparam logic [31:0] I_BLTU = 32'h0020E463;
  localparam logic [31:0] I_JAL  = 32'h010000EF;

  rv_mc_ctrl #(.XLEN(32), .RESET_PC_SEL(0)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .instr        (instr),
    .mem_ready    (mem_ready),
    .alu_res_zero (alu_res_zero),
    .alu_res_lsb  (alu_res_lsb),
    .alu_op       (alu_op),
    .src_a_sel    (src_a_sel),
    .src_b_sel    (src_b_sel),
    .imm_sel      (imm_sel),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .addr_sel     (addr_sel),
    .ir_we        (ir_we),
    .pc_we        (pc_we),
    .rf_we        (rf_we),
    .wb_sel       (wb_sel),
    .illegal      (illegal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; instr = 32'h0; mem_ready = 1'b0; alu_res_zero = 1'b0; alu_res_lsb = 1'b0;
    tick(); tick();
    mem_ready = 1'b1; #1;
    chk("rst_mem_req", 32'(mem_req), 0);
    chk("rst_ir_we",   32'(ir_we),   0);
    chk("rst_pc_we",   32'(pc_we),   0);
    chk("rst_rf_we",   32'(rf_we),   0);
    chk("rst_illegal", 32'(illegal), 0);

    // add x3,x1,x2: FETCH(1) DECODE(2) EXEC_R(3) WB_ALU(4) FETCH(5)
    rst_n = 1'b1; instr = I_ADD; #1;
    chk("fetch_mem_req",  32'(mem_req),   1);
    chk("fetch_addr_sel", 32'(addr_sel),  0);
    chk("fetch_src_a",    32'(src_a_sel), 1);
    chk("fetch_src_b",    32'(src_b_sel), 2);
    chk("fetch_alu_op",   32'(alu_op),    32'(ALU_ADD));
    chk("fetch_ir_we",    32'(ir_we),     1);
    chk("fetch_pc_we",    32'(pc_we),     1);
    tick();
    chk("dec_src_a",   32'(src_a_sel), 2);
    chk("dec_src_b",   32'(src_b_sel), 1);
    chk("dec_imm_sel", 32'(imm_sel),   2);
    chk("dec_ir_we",   32'(ir_we),     0);
    tick();
    chk("add_alu_op", 32'(alu_op),    32'(ALU_ADD));
    chk("add_src_a",  32'(src_a_sel), 0);
    chk("add_src_b",  32'(src_b_sel), 0);
    chk("add_rf_we3", 32'(rf_we),     0);
    tick();
    chk("add_rf_we4",  32'(rf_we),  1);
    chk("add_wb_sel",  32'(wb_sel), 0);
    tick();
    chk("add_fetch5_req",   32'(mem_req), 1);
    chk("add_fetch5_rf_we", 32'(rf_we),   0);

    // sub
    instr = I_SUB; tick(); tick();
    chk("sub_alu_op", 32'(alu_op), 32'(ALU_SUB));
    tick(); tick();

    // srai x5,x6,3
    instr = I_SRAI; tick(); tick();
    chk("srai_alu_op",  32'(alu_op),    32'(ALU_SRA));
    chk("srai_src_b",   32'(src_b_sel), 1);
    chk("srai_imm_sel", 32'(imm_sel),   0);
    tick(); tick();

    // lw x1,4(x2) with three wait cycles
    instr = I_LW; tick(); tick();
    chk("lw_addr_alu_op", 32'(alu_op),    32'(ALU_ADD));
    chk("lw_addr_src_b",  32'(src_b_sel), 1);
    chk("lw_addr_imm",    32'(imm_sel),   0);
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("lw_wait_req",  32'(mem_req),  1);
      chk("lw_wait_addr", 32'(addr_sel), 1);
      chk("lw_wait_we",   32'(mem_we),   0);
    end
    tick(); mem_ready = 1'b1; #1;
    chk("lw_ready_req",   32'(mem_req),  1);
    chk("lw_ready_addr",  32'(addr_sel), 1);
    chk("lw_ready_rf_we", 32'(rf_we),    0);
    tick();
    chk("lw_wb_rf_we", 32'(rf_we),  1);
    chk("lw_wb_sel",   32'(wb_sel), 1);
    tick();
    chk("lw_fetch_req", 32'(mem_req), 1);

    // beq taken
    instr = I_BEQ; tick(); tick();
    alu_res_zero = 1'b1; #1;
    chk("beq_alu_op",   32'(alu_op), 32'(ALU_SUB));
    chk("beq_tk_pc_we", 32'(pc_we),  1);
    chk("beq_rf_we",    32'(rf_we),  0);
    tick(); alu_res_zero = 1'b0;
    // beq not taken
    tick(); tick(); #1;
    chk("beq_nt_pc_we", 32'(pc_we), 0);
    tick();

    // bltu taken on lsb
    instr = I_BLTU; tick(); tick();
    alu_res_lsb = 1'b1; #1;
    chk("bltu_alu_op", 32'(alu_op), 32'(ALU_SLTU));
    chk("bltu_pc_we",  32'(pc_we),  1);
    tick(); alu_res_lsb = 1'b0;

    // jal x1,+16
    instr = I_JAL; tick(); tick();
    chk("jal_rf_we",   32'(rf_we),     1);
    chk("jal_wb_sel",  32'(wb_sel),    2);
    chk("jal_pc_we",   32'(pc_we),     1);
    chk("jal_src_a",   32'(src_a_sel), 2);
    chk("jal_src_b",   32'(src_b_sel), 1);
    chk("jal_imm_sel", 32'(imm_sel),   4);
    tick();
    chk("jal_fetch_req", 32'(mem_req), 1);

    // funct7=0000001 R-type traps and stays quiet
    instr = I_BAD; tick(); tick(); tick(); tick();
    chk("trap_illegal", 32'(illegal), 1);
    chk("trap_mem_req", 32'(mem_req), 0);
    chk("trap_ir_we",   32'(ir_we),   0);
    chk("trap_pc_we",   32'(pc_we),   0);
    chk("trap_rf_we",   32'(rf_we),   0);
    tick();
    chk("trap_hold_illegal", 32'(illegal), 1);
    chk("trap_hold_mem_req", 32'(mem_req), 0);
    rst_n = 1'b0; tick();
    chk("trap_rst_illegal", 32'(illegal), 0);
    rst_n = 1'b1; #1;
    chk("trap_rst_fetch", 32'(mem_req), 1);

    // sw aborted by reset while waiting in MEM_WR
    instr = I_SW; tick(); tick();
    chk("sw_addr_imm", 32'(imm_sel), 1);
    mem_ready = 1'b0; tick();
    chk("sw_mem_we",   32'(mem_we),   1);
    chk("sw_mem_req",  32'(mem_req),  1);
    chk("sw_addr_sel", 32'(addr_sel), 1);
    tick(); rst_n = 1'b0; #1;
    chk("sw_rst_mem_we",  32'(mem_we),  0);
    chk("sw_rst_mem_req", 32'(mem_req), 0);
    tick(); rst_n = 1'b1; mem_ready = 1'b1; #1;
    chk("sw_after_req",     32'(mem_req),   1);
    chk("sw_after_addr",    32'(addr_sel),  0);
    chk("sw_after_src_a",   32'(src_a_sel), 1);
    chk("sw_after_mem_we",  32'(mem_we),    0);
    chk("sw_after_illegal", 32'(illegal),   0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
